fixed_point_adder_arbiter: RTL and testbench
============================================

FIXED_POINT_ADDER_ARBITER -- requirements
Module: fixed_point_adder_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one adder; SHALL be 2..8.
REQ-002 Parameter DATA_W, default 26: fixed-point operand and result width.
REQ-003 Parameter ADD_LAT, default 1: cycles from the adder's Port1/Port2 inputs to its registered output; SHALL be 1..4.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 GlobalReset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
REQ-008 req_a  input  NUM_REQ*DATA_W  operand A; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 req_b  input  NUM_REQ*DATA_W  operand B; same packing as req_a.
REQ-010 add_port1  output  DATA_W  registered operand A to the shared adder.
REQ-011 add_port2  output  DATA_W  registered operand B to the shared adder.
REQ-012 add_result  input  DATA_W  shared adder registered output.
REQ-013 rsp_valid  output  1  single-cycle result strobe.
REQ-014 rsp_id  output  clog2(NUM_REQ)  index of the requester that owns rsp_data.
REQ-015 rsp_data  output  DATA_W  sum returned to the requester.

Function
REQ-016 A handshake SHALL occur on requester i in cycle t when req_valid[i] and req_ready[i] are both 1.
REQ-017 req_ready SHALL be combinational from req_valid and the priority pointer, and SHALL assert for at most one requester per cycle.
REQ-018 With no requester valid, req_ready SHALL be all zero.
REQ-019 Grant SHALL go to the first valid requester searching upward from rr_ptr, with wrap from NUM_REQ-1 to 0.
REQ-020 After a grant to index g, rr_ptr SHALL become (g+1) mod NUM_REQ. With no grant, rr_ptr SHALL hold.
REQ-021 On a handshake in cycle t, add_port1/add_port2 SHALL carry that requester's operands from cycle t+1.
REQ-022 add_port1/add_port2 SHALL hold their last values in cycles with no handshake.
REQ-023 A tag pipeline of depth ADD_LAT+1 SHALL carry {valid, id} alongside each accepted operation.
REQ-024 rsp_valid, rsp_id and rsp_data SHALL be registered and SHALL present an operation accepted in cycle t in cycle t+2+ADD_LAT (t+3 at default).
REQ-025 rsp_data SHALL be add_result sampled when the matching tag emerges; no width change or arithmetic SHALL occur in this block.
REQ-026 The block SHALL sustain one accepted operation per cycle; responses SHALL return in acceptance order with no backpressure.
REQ-027 rsp_id and rsp_data SHALL hold their last values while rsp_valid is 0.
REQ-028 A requester SHALL wait no more than NUM_REQ-1 cycles for a grant while held valid, in round-robin mode.

Reset
REQ-029 While GlobalReset is 1 at a rising edge, the following SHALL clear to 0: rr_ptr, all tag pipeline valids, add_port1, add_port2, rsp_valid, rsp_id and rsp_data.
REQ-030 req_ready SHALL be all zero while GlobalReset is 1.
REQ-031 Operations accepted before a mid-operation reset SHALL be discarded; no rsp_valid SHALL appear for them.

Configuration
REQ-032 The macro FPADD_ARB_FIXED_PRIO_EN, when defined, SHALL replace round-robin with fixed priority: lowest valid index wins and rr_ptr is removed.
REQ-033 When FPADD_ARB_FIXED_PRIO_EN is not defined, round-robin per REQ-019/REQ-020 SHALL apply; all other behaviour is identical in both builds.

Verification
REQ-034 Single requester: reset, then req0 with A=100, B=300 held one cycle in t -> req_ready[0]=1 in t; rsp_valid=1, rsp_id=0, rsp_data=400 in t+3.
REQ-035 All four requesters valid continuously from rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; results return in that order, one per cycle.
REQ-036 Wrap: req3 and req1 valid with rr_ptr=3 -> req3 granted first, then req1; rsp_id sequence 3,1.
REQ-037 Reset mid-flight: accept A=500, B=800, then assert GlobalReset in t+1 -> no rsp_valid through t+5; all outputs 0 after the reset edge.
REQ-038 FPADD_ARB_FIXED_PRIO_EN defined with req0 and req2 valid continuously -> req0 granted every cycle; req2 is granted only after req0 drops. Use A=1000, B=2000 -> rsp_data=3000.
REQ-039 Idle: no req_valid for 10 cycles -> req_ready=0 and rsp_valid=0 throughout; add_port1/add_port2 unchanged.

Source files
------------

// File: rtl/fixed_point_adder_arbiter.sv
// fixed_point_adder_arbiter
// Shares one externally registered fixed-point adder between NUM_REQ
// requesters. A combinational arbiter picks one valid requester per cycle,
// its operands are registered onto add_port1/add_port2, and a {valid, id}
// tag pipeline runs alongside the adder so that the adder result can be
// returned with the owning requester's index.
//
// Build option: define FPADD_ARB_FIXED_PRIO_EN to replace round-robin
// arbitration with fixed priority (lowest valid index wins, no rr_ptr).
//
// Timing for an operation accepted in cycle t:
//   t+1            operands on add_port1/add_port2, tag stage 0
//   t+1+ADD_LAT    add_result valid, tag stage ADD_LAT
//   t+2+ADD_LAT    rsp_valid/rsp_id/rsp_data
module fixed_point_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 26,
  parameter int ADD_LAT = 1,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      GlobalReset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         add_port1,
  output logic [DATA_W-1:0]         add_port2,
  input  logic [DATA_W-1:0]         add_result,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fixed_point_adder_arbiter: NUM_REQ must be 2..8");
  end
  if (ADD_LAT < 1 || ADD_LAT > 4) begin : g_bad_add_lat
    $error("fixed_point_adder_arbiter: ADD_LAT must be 1..4");
  end

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               hs;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;

  logic [ADD_LAT:0]   tag_valid;
  logic [ID_W-1:0]    tag_id [ADD_LAT+1];

`ifdef FPADD_ARB_FIXED_PRIO_EN

  // Fixed priority: scan from the top down so the lowest valid index is the
  // last (winning) assignment.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    hs       = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant_id = ID_W'(k);
        hs       = 1'b1;
      end
    end
    if (GlobalReset) begin
      hs = 1'b0;
    end
    if (hs) begin
      grant[grant_id] = 1'b1;
    end
  end

`else

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cand;

  // Round-robin: walk candidates from farthest to nearest offset from
  // rr_ptr, so the first valid requester at or above rr_ptr (with wrap)
  // ends up as the winner.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    hs       = 1'b0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_id = cand;
        hs       = 1'b1;
      end
    end
    if (GlobalReset) begin
      hs = 1'b0;
    end
    if (hs) begin
      grant[grant_id] = 1'b1;
    end
  end

  // Priority pointer moves one past the winner; holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      rr_ptr <= '0;
    end else if (hs) begin
      if (grant_id == ID_W'(NUM_REQ - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= grant_id + ID_W'(1);
      end
    end
  end

`endif

  assign req_ready = grant;

  // Operand select for the granted requester (grant is one-hot or zero).
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_a = req_a[k*DATA_W +: DATA_W];
        sel_b = req_b[k*DATA_W +: DATA_W];
      end
    end
  end

  // Adder input registers; they keep their value between handshakes.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      add_port1 <= '0;
      add_port2 <= '0;
    end else if (hs) begin
      add_port1 <= sel_a;
      add_port2 <= sel_b;
    end
  end

  // Tag pipeline: stage k lines up with the operation k cycles after the
  // operands reach the adder; stage ADD_LAT lines up with add_result.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      tag_valid <= '0;
      for (int k = 0; k <= ADD_LAT; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      tag_valid <= {tag_valid[ADD_LAT-1:0], hs};
      tag_id[0] <= grant_id;
      for (int k = 1; k <= ADD_LAT; k++) begin
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  // Response register; id/data hold their last value while no tag emerges.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_valid[ADD_LAT];
      if (tag_valid[ADD_LAT]) begin
        rsp_id   <= tag_id[ADD_LAT];
        rsp_data <= add_result;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_adder_arbiter.sv
// Bench for fixed_point_adder_arbiter: models the external adder, keeps a
// request-level reference model (arbitration by index arithmetic, a queue of
// due responses), and runs directed tables, hand sequences and random traffic.
module tb_fixed_point_adder_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 26;
  localparam int ADD_LAT = 1;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      GlobalReset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [DATA_W-1:0]         add_port1;
  logic [DATA_W-1:0]         add_port2;
  logic [DATA_W-1:0]         add_result;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;

  fixed_point_adder_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADD_LAT(ADD_LAT)
  ) dut (
    .clk(clk), .GlobalReset(GlobalReset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_port1(add_port1), .add_port2(add_port2), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // External shared adder with ADD_LAT register stages.
  logic [DATA_W-1:0] add_pipe [ADD_LAT];
  always @(posedge clk) begin
    add_pipe[0] <= add_port1 + add_port2;
    for (int k = 1; k < ADD_LAT; k++) add_pipe[k] <= add_pipe[k-1];
  end
  assign add_result = add_pipe[ADD_LAT-1];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    req_a[i*DATA_W +: DATA_W] = a;
    req_b[i*DATA_W +: DATA_W] = b;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int                due;
    int                id;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t              q[$];
  rsp_t              head;
  bit                mon_en = 1'b0;
  int                cyc = 0;
  int                m_ptr = 0;
  logic [DATA_W-1:0] m_p1 = '0;
  logic [DATA_W-1:0] m_p2 = '0;
  int                h_id = 0;
  logic [DATA_W-1:0] h_data = '0;
  int                g;
  int                idx;
  logic [NUM_REQ-1:0] exp_ready;
  logic [DATA_W-1:0] m_sum;

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      g = -1;
      exp_ready = '0;
      if (!GlobalReset) begin
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FPADD_ARB_FIXED_PRIO_EN
          idx = k;
`else
          idx = (m_ptr + k) % NUM_REQ;
`endif
          if (g < 0 && req_valid[idx]) g = idx;
        end
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      check("mon_ready", 64'(req_ready), 64'(exp_ready));
      check("mon_port1", 64'(add_port1), 64'(m_p1));
      check("mon_port2", 64'(add_port2), 64'(m_p2));
      if (q.size() > 0 && q[0].due == cyc) begin
        head = q.pop_front();
        h_id = head.id;
        h_data = head.data;
        check("mon_rsp_valid", 64'(rsp_valid), 64'(1));
      end else begin
        check("mon_rsp_valid", 64'(rsp_valid), 64'(0));
      end
      check("mon_rsp_id", 64'(rsp_id), 64'(h_id));
      check("mon_rsp_data", 64'(rsp_data), 64'(h_data));
      if (GlobalReset) begin
        q.delete();
        m_ptr = 0; m_p1 = '0; m_p2 = '0; h_id = 0; h_data = '0;
      end else if (g >= 0) begin
        m_p1 = req_a[g*DATA_W +: DATA_W];
        m_p2 = req_b[g*DATA_W +: DATA_W];
        m_sum = m_p1 + m_p2;
        q.push_back('{cyc + 2 + ADD_LAT, g, m_sum});
        m_ptr = (g + 1) % NUM_REQ;
      end
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
    logic       rv;
    int         id;
    int         data;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // requester i: A = 100*(i+1), B = i+1 -> sum 101*(i+1)
    tbl[0]  = '{4'hF, 4'h1, 1'b0, 0, 0};
    tbl[1]  = '{4'hF, 4'h2, 1'b0, 0, 0};
    tbl[2]  = '{4'hF, 4'h4, 1'b0, 0, 0};
    tbl[3]  = '{4'hF, 4'h8, 1'b1, 0, 101};
    tbl[4]  = '{4'hF, 4'h1, 1'b1, 1, 202};
    tbl[5]  = '{4'h0, 4'h0, 1'b1, 2, 303};
    tbl[6]  = '{4'h0, 4'h0, 1'b1, 3, 404};
    tbl[7]  = '{4'h0, 4'h0, 1'b1, 0, 101};
    tbl[8]  = '{4'h4, 4'h4, 1'b0, 0, 101};
    tbl[9]  = '{4'hA, 4'h8, 1'b0, 0, 101};
    tbl[10] = '{4'hA, 4'h2, 1'b0, 0, 101};
    tbl[11] = '{4'h0, 4'h0, 1'b1, 2, 303};
    tbl[12] = '{4'h0, 4'h0, 1'b1, 3, 404};
    tbl[13] = '{4'h0, 4'h0, 1'b1, 1, 202};
    tbl[14] = '{4'h0, 4'h0, 1'b0, 1, 202};

    GlobalReset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'hF;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_ready", 64'(req_ready), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_data", 64'(rsp_data), 64'(0));
    check("reset_port1", 64'(add_port1), 64'(0));

    // single requester
    tick();
    GlobalReset = 1'b0;
    req_valid = 4'h1;
    set_op(0, 100, 300);
    @(negedge clk);
    check("single_ready", 64'(req_ready), 64'(1));
    tick();
    req_valid = 4'h0;
    @(negedge clk);
    check("single_port1", 64'(add_port1), 64'(100));
    check("single_port2", 64'(add_port2), 64'(300));
    tick();
    @(negedge clk);
    check("single_early", 64'(rsp_valid), 64'(0));
    tick();
    @(negedge clk);
    check("single_rsp_valid", 64'(rsp_valid), 64'(1));
    check("single_rsp_id", 64'(rsp_id), 64'(0));
    check("single_rsp_data", 64'(rsp_data), 64'(400));

    // idle
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      check("idle_ready", 64'(req_ready), 64'(0));
      check("idle_rsp_valid", 64'(rsp_valid), 64'(0));
      check("idle_port1", 64'(add_port1), 64'(100));
      check("idle_port2", 64'(add_port2), 64'(300));
    end

    // reset so arbitration starts from index 0
    tick();
    GlobalReset = 1'b1;
    tick();
    GlobalReset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, DATA_W'(100 * (i + 1)), DATA_W'(i + 1));

`ifndef FPADD_ARB_FIXED_PRIO_EN
    for (int r = 0; r < 15; r++) begin
      req_valid = tbl[r].valid;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].ready));
      check($sformatf("tbl%0d_rsp_valid", r), 64'(rsp_valid), 64'(tbl[r].rv));
      check($sformatf("tbl%0d_rsp_id", r), 64'(rsp_id), 64'(tbl[r].id));
      check($sformatf("tbl%0d_rsp_data", r), 64'(rsp_data), 64'(tbl[r].data));
      tick();
    end
`else
    set_op(0, 1000, 2000);
    req_valid = 4'h5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("fixed_ready", 64'(req_ready), 64'(1));
      if (i == 3) begin
        check("fixed_rsp_id", 64'(rsp_id), 64'(0));
        check("fixed_rsp_data", 64'(rsp_data), 64'(3000));
      end
      tick();
    end
    req_valid = 4'h4;
    @(negedge clk);
    check("fixed_ready_req2", 64'(req_ready), 64'(4));
    tick();
`endif

    // reset with an operation in flight
    req_valid = 4'h1;
    set_op(0, 500, 800);
    @(negedge clk);
    check("midrst_ready", 64'(req_ready), 64'(1));
    tick();
    req_valid = 4'h0;
    GlobalReset = 1'b1;
    @(negedge clk);
    tick();
    GlobalReset = 1'b0;
    @(negedge clk);
    check("midrst_port1", 64'(add_port1), 64'(0));
    check("midrst_port2", 64'(add_port2), 64'(0));
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midrst_rsp_id", 64'(rsp_id), 64'(0));
    check("midrst_rsp_data", 64'(rsp_data), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("midrst_no_rsp", 64'(rsp_valid), 64'(0));
    end

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      tick();
      GlobalReset = ($urandom_range(0, 49) == 0);
      req_valid = NUM_REQ'($urandom_range(0, 15));
      for (int i = 0; i < NUM_REQ; i++) set_op(i, DATA_W'($urandom), DATA_W'($urandom));
    end
    tick();
    GlobalReset = 1'b0;
    req_valid = '0;
    repeat (6) tick();
    @(negedge clk);
    check("drain_empty", 64'(q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
